// File: rtl/ps2_key_scheduler.sv
// ps2_key_scheduler: decodes PS/2 set 2 make/break bytes into the held state
// of the four paddle keys (W, S, I, K) and, once every REPEAT_FRAMES frame
// ticks, issues one move command per eligible held key to the paddle datapath.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   rx_code      : byte from the PS/2 receiver, valid when rx_ready pulses
//   rx_ready     : one-cycle receive strobe
//   frame_tick   : one-cycle strobe per video frame
//   scan_code    : move command (0x1D W, 0x1B S, 0x43 I, 0x42 K), holds last value
//   scan_ready   : one-cycle strobe, high in each issuing cycle
//   keys_held    : held key state {K,I,S,W}
module ps2_key_scheduler #(
  parameter int unsigned REPEAT_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_code,
  input  logic       rx_ready,
  input  logic       frame_tick,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic [3:0] keys_held
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned KEYS_W = 4;
  localparam int unsigned FCNT_W = 8;

  localparam logic [CODE_W-1:0] CODE_W_KEY = 8'h1D;
  localparam logic [CODE_W-1:0] CODE_S_KEY = 8'h1B;
  localparam logic [CODE_W-1:0] CODE_I_KEY = 8'h43;
  localparam logic [CODE_W-1:0] CODE_K_KEY = 8'h42;
  localparam logic [CODE_W-1:0] CODE_BRK   = 8'hF0;
  localparam logic [CODE_W-1:0] CODE_EXT   = 8'hE0;

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(REPEAT_FRAMES - 1);

  typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXTBRK} dec_state_e;
  typedef enum logic {S_IDLE, S_ISSUE} sch_state_e;

  dec_state_e          dec_q, dec_d;
  sch_state_e          sch_q, sch_d;
  logic [KEYS_W-1:0]   keys_q, keys_d;
  logic [KEYS_W-1:0]   pend_q, pend_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                ready_q, ready_d;

  logic                burst_c;
  logic [KEYS_W-1:0]   elig_c;
  logic [KEYS_W-1:0]   lowest_c;

  // One-hot key position of a paddle make/break code, zero for other bytes.
  function automatic logic [KEYS_W-1:0] key_mask(input logic [CODE_W-1:0] c);
    case (c)
      CODE_W_KEY: key_mask = 4'b0001;
      CODE_S_KEY: key_mask = 4'b0010;
      CODE_I_KEY: key_mask = 4'b0100;
      CODE_K_KEY: key_mask = 4'b1000;
      default:    key_mask = 4'b0000;
    endcase
  endfunction

  // Move command for a one-hot key position.
  function automatic logic [CODE_W-1:0] key_code(input logic [KEYS_W-1:0] m);
    case (m)
      4'b0001: key_code = CODE_W_KEY;
      4'b0010: key_code = CODE_S_KEY;
      4'b0100: key_code = CODE_I_KEY;
      4'b1000: key_code = CODE_K_KEY;
      default: key_code = 8'h00;
    endcase
  endfunction

  // Opposing keys on the same side cancel each other.
  assign elig_c = {keys_q[3] & ~keys_q[2], keys_q[2] & ~keys_q[3],
                   keys_q[1] & ~keys_q[0], keys_q[0] & ~keys_q[1]};

  // Isolate the lowest set pending bit (W has highest priority).
  assign lowest_c = pend_q & (~pend_q + KEYS_W'(1));

  assign burst_c = frame_tick && (fcnt_q == FCNT_LAST);

  // Next-state logic for decoder, frame divider and scheduler.
  always_comb begin
    dec_d   = dec_q;
    keys_d  = keys_q;
    fcnt_d  = fcnt_q;
    sch_d   = sch_q;
    pend_d  = pend_q;
    code_d  = code_q;
    ready_d = 1'b0;

    if (rx_ready) begin
      case (dec_q)
        D_IDLE: begin
          if (rx_code == CODE_BRK)      dec_d = D_BRK;
          else if (rx_code == CODE_EXT) dec_d = D_EXT;
          else                          keys_d = keys_q | key_mask(rx_code);
        end
        D_BRK: begin
          keys_d = keys_q & ~key_mask(rx_code);
          dec_d  = D_IDLE;
        end
        D_EXT:    dec_d = (rx_code == CODE_BRK) ? D_EXTBRK : D_IDLE;
        D_EXTBRK: dec_d = D_IDLE;
        default:  dec_d = D_IDLE;
      endcase
    end

    if (frame_tick) begin
      fcnt_d = burst_c ? '0 : fcnt_q + FCNT_W'(1);
    end

    case (sch_q)
      S_IDLE: begin
        // Snapshot uses the registered key state, before any same-cycle update.
        if (burst_c && (elig_c != '0)) begin
          pend_d = elig_c;
          sch_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Burst requests arriving here are dropped by design.
        code_d  = key_code(lowest_c);
        ready_d = 1'b1;
        pend_d  = pend_q & ~lowest_c;
        if (pend_d == '0) sch_d = S_IDLE;
      end
      default: sch_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= D_IDLE;
      sch_q   <= S_IDLE;
      keys_q  <= '0;
      pend_q  <= '0;
      fcnt_q  <= '0;
      code_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      sch_q   <= sch_d;
      keys_q  <= keys_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      code_q  <= code_d;
      ready_q <= ready_d;
    end
  end

  assign scan_code  = code_q;
  assign scan_ready = ready_q;
  assign keys_held  = keys_q;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed bench for ps2_key_scheduler: one instance with REPEAT_FRAMES=1
// and one with REPEAT_FRAMES=3 share all inputs.
module tb_ps2_key_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_code;
  logic       rx_ready;
  logic       frame_tick;

  logic [7:0] code1, code3;
  logic       rdy1, rdy3;
  logic [3:0] keys1, keys3;

  int errors = 0;
  int checks = 0;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  ps2_key_scheduler #(.REPEAT_FRAMES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_code(rx_code), .rx_ready(rx_ready),
    .frame_tick(frame_tick), .scan_code(code1), .scan_ready(rdy1), .keys_held(keys1)
  );

  ps2_key_scheduler #(.REPEAT_FRAMES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .rx_code(rx_code), .rx_ready(rx_ready),
    .frame_tick(frame_tick), .scan_code(code3), .scan_ready(rdy3), .keys_held(keys3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (rdy1) q1.push_back(code1);
    if (rdy3) q3.push_back(code3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_code  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Returns at the negedge just after the tick's active edge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rx_code = 8'h00; rx_ready = 1'b0; frame_tick = 1'b0;
    idle(3);
    chk("rst_ready", 32'(rdy1), 32'h0);
    chk("rst_code", 32'(code1), 32'h00);
    chk("rst_keys", 32'(keys1), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Hold W, three ticks, release, two ticks.
    send(8'h1D);
    chk("w_held", 32'(keys1), 32'b0001);
    q1.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_snap_quiet", 32'(rdy1), 32'h0);
      @(negedge clk);
      chk("w_strobe", 32'(rdy1), 32'h1);
      chk("w_code", 32'(code1), 32'h1D);
      @(negedge clk);
      chk("w_single", 32'(rdy1), 32'h0);
    end
    send(8'hF0);
    send(8'h1D);
    chk("w_released", 32'(keys1), 32'b0000);
    tick(); idle(3);
    tick(); idle(3);
    chk("w_count", 32'(q1.size()), 32'd3);

    // Both sides: W and K.
    send(8'h1D);
    send(8'h42);
    chk("wk_held", 32'(keys1), 32'b1001);
    q1.delete();
    tick();
    chk("wk_snap_quiet", 32'(rdy1), 32'h0);
    @(negedge clk);
    chk("wk_first_rdy", 32'(rdy1), 32'h1);
    chk("wk_first_code", 32'(code1), 32'h1D);
    @(negedge clk);
    chk("wk_second_rdy", 32'(rdy1), 32'h1);
    chk("wk_second_code", 32'(code1), 32'h42);
    @(negedge clk);
    chk("wk_done_rdy", 32'(rdy1), 32'h0);
    chk("wk_code_hold", 32'(code1), 32'h42);
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h42);
    chk("wk_released", 32'(keys1), 32'b0000);

    // Left conflict.
    send(8'h1D);
    send(8'h1B);
    chk("ws_held", 32'(keys1), 32'b0011);
    q1.delete();
    tick(); idle(4);
    chk("ws_no_strobe", 32'(q1.size()), 32'd0);
    send(8'hF0); send(8'h1B);
    chk("ws_s_released", 32'(keys1), 32'b0001);
    tick(); idle(4);
    chk("ws_count", 32'(q1.size()), 32'd1);
    if (q1.size() > 0) chk("ws_code", 32'(q1[0]), 32'h1D);
    send(8'hF0); send(8'h1D);

    // Extended-code filtering.
    send(8'hE0); send(8'h1D);
    send(8'hE0); send(8'hF0); send(8'h1D);
    chk("ext_ignored", 32'(keys1), 32'b0000);
    send(8'h1D);
    chk("ext_then_make", 32'(keys1), 32'b0001);
    send(8'hF0); send(8'h1D);

    // Reset mid-burst.
    send(8'h1D); send(8'h42);
    tick();
    @(negedge clk);
    chk("mid_first_rdy", 32'(rdy1), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rdy1), 32'h0);
    chk("mid_rst_keys", 32'(keys1), 32'h0);
    chk("mid_rst_code", 32'(code1), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    q1.delete();
    idle(3);
    tick(); idle(3);
    tick(); idle(3);
    chk("post_rst_quiet", 32'(q1.size()), 32'd0);

    // Reset forgets a pending break prefix.
    send(8'hF0);
    do_reset();
    send(8'h1D);
    chk("prefix_forgot", 32'(keys1), 32'b0001);
    send(8'hF0); send(8'h1D);

    // Frame divider with REPEAT_FRAMES=3.
    do_reset();
    send(8'h43);
    chk("i_held", 32'(keys3), 32'b0100);
    q3.delete();
    tick(); idle(3);
    tick(); idle(3);
    chk("div_tick2", 32'(q3.size()), 32'd0);
    tick();
    chk("div_t3_quiet", 32'(rdy3), 32'h0);
    @(negedge clk);
    chk("div_t3_rdy", 32'(rdy3), 32'h1);
    chk("div_t3_code", 32'(code3), 32'h43);
    idle(2);
    tick(); idle(3);
    tick(); idle(3);
    chk("div_tick5", 32'(q3.size()), 32'd1);
    tick(); idle(3);
    chk("div_tick6", 32'(q3.size()), 32'd2);
    tick(); idle(3);
    tick(); idle(3);
    chk("div_tick8", 32'(q3.size()), 32'd2);
    send(8'hF0);
    // Final break byte coincides with tick 9.
    @(negedge clk);
    rx_code = 8'h43; rx_ready = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; frame_tick = 1'b0;
    chk("div_t9_keys", 32'(keys3), 32'b0000);
    chk("div_t9_quiet", 32'(rdy3), 32'h0);
    @(negedge clk);
    chk("div_t9_rdy", 32'(rdy3), 32'h1);
    chk("div_t9_code", 32'(code3), 32'h43);
    idle(2);
    tick(); idle(3);
    tick(); idle(3);
    tick(); idle(3);
    chk("div_total", 32'(q3.size()), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
